branch_resolve_unit: RTL and testbench

- Parametrised, pipelined successor to the single-cycle ID-stage branch comparator.
- Accepts one branch op per cycle over valid/ready, evaluates all six RISC-V conditional branches at width XLEN, and computes the taken decision, the redirect PC and the mispredict flag against the front-end prediction.
- Sits between decode and the fetch redirect logic; a flush input kills in-flight ops.

---
 rtl/branch_resolve_unit.sv | 163 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Pipelined RISC-V conditional-branch resolver: taken, redirect PC and mispredict over valid/ready.
// Optional resolved/mispredict counters are compiled in with `define BRANCH_STATS_EN.
module branch_resolve_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PIPE_DEPTH = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic             is_branch,
    input  logic [2:0]       branch_type,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             illegal,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int unsigned LAST = PIPE_DEPTH - 1;

    typedef struct packed {
        logic            taken;
        logic            mispredict;
        logic            illegal;
`ifdef BRANCH_STATS_EN
        logic            counted;
`endif
        logic [XLEN-1:0] redirect_pc;
    } stage_t;

    logic [PIPE_DEPTH-1:0] vld_q, vld_d;
    stage_t                pay_q [PIPE_DEPTH];
    stage_t                pay_d [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] can_take;
    stage_t                res;

    logic eq, lt, ltu, cond, legal, taken_c;

    always_comb begin
        eq      = (a == b);
        lt      = ($signed(a) < $signed(b));
        ltu     = (a < b);
        cond    = 1'b0;
        legal   = 1'b1;
        case (branch_type)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b100:  cond = lt;
            3'b101:  cond = !lt;
            3'b110:  cond = ltu;
            3'b111:  cond = !ltu;
            default: legal = 1'b0;
        endcase
        taken_c         = is_branch && legal && cond;
        res             = '0;
        res.taken       = taken_c;
        res.illegal     = is_branch && !legal;
        res.mispredict  = taken_c ^ pred_taken;
`ifdef BRANCH_STATS_EN
        res.counted     = is_branch && legal;
`endif
        res.redirect_pc = taken_c ? (pc + imm) : (pc + XLEN'(4));
    end

    // A stage can load when it is empty or its occupant moves on; evaluated from the output backwards.
    always_comb begin
        can_take = '0;
        for (int unsigned i = PIPE_DEPTH; i > 0; i--) begin
            if (i == PIPE_DEPTH)
                can_take[i-1] = !vld_q[i-1] || out_ready;
            else
                can_take[i-1] = !vld_q[i-1] || can_take[i];
        end
    end

    assign in_ready = can_take[0];

    always_comb begin
        vld_d = vld_q;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++)
            pay_d[i] = pay_q[i];

        if (flush) begin
            vld_d = '0;
        end else begin
            if (can_take[0]) begin
                vld_d[0] = in_valid;
                if (in_valid)
                    pay_d[0] = res;
            end
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                if (can_take[i]) begin
                    vld_d[i] = vld_q[i-1];
                    if (vld_q[i-1])
                        pay_d[i] = pay_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++)
                pay_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++)
                pay_q[i] <= pay_d[i];
        end
    end

    assign out_valid   = vld_q[LAST];
    assign taken       = pay_q[LAST].taken;
    assign mispredict  = pay_q[LAST].mispredict;
    assign illegal     = pay_q[LAST].illegal;
    assign redirect_pc = pay_q[LAST].redirect_pc;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

    // Handshake counts even when it coincides with flush; counters saturate.
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (out_valid && out_ready && pay_q[LAST].counted) begin
            if (br_cnt_q != '1)
                br_cnt_d = br_cnt_q + 1'b1;
            if (pay_q[LAST].mispredict && (mp_cnt_q != '1))
                mp_cnt_d = mp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mp_cnt_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver pushes reference results, negedge monitor pops and compares.
module tb_branch_resolve_unit;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned PIPE_DEPTH = 3;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned SAT        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic             is_branch;
    logic [2:0]       branch_type;
    logic [XLEN-1:0]  a, b, pc, imm;
    logic             pred_taken;
    logic             out_valid;
    logic             out_ready;
    logic             taken;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic             illegal;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    branch_resolve_unit #(
        .XLEN(XLEN),
        .PIPE_DEPTH(PIPE_DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .is_branch(is_branch),
        .branch_type(branch_type),
        .a(a),
        .b(b),
        .pc(pc),
        .imm(imm),
        .pred_taken(pred_taken),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .taken(taken),
        .mispredict(mispredict),
        .redirect_pc(redirect_pc),
        .illegal(illegal),
        .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            taken;
        logic            mispred;
        logic            illegal;
        logic            counted;
        logic [XLEN-1:0] rpc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned model_br = 0;
    int unsigned model_mp = 0;
    bit          rand_ready = 0;

    task automatic check(string name, longint act, longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic longint stat_exp(int unsigned v);
`ifdef BRANCH_STATS_EN
        return longint'(v);
`else
        return 0;
`endif
    endfunction

    // Reference: branch rules evaluated on integers, not on bit-level comparators.
    function automatic exp_t model(logic ib, logic [2:0] bt, logic [XLEN-1:0] av, logic [XLEN-1:0] bv,
                                   logic [XLEN-1:0] pcv, logic [XLEN-1:0] immv, logic pt);
        exp_t   e;
        longint ua, ub, sa, sb, nxt;
        bit     legal;
        bit     t;
        ua    = longint'(av);
        ub    = longint'(bv);
        sa    = av[XLEN-1] ? ua - (longint'(1) << XLEN) : ua;
        sb    = bv[XLEN-1] ? ub - (longint'(1) << XLEN) : ub;
        legal = 1;
        t     = 0;
        case (bt)
            3'd0:    t = (ua == ub);
            3'd1:    t = (ua != ub);
            3'd4:    t = (sa < sb);
            3'd5:    t = (sa >= sb);
            3'd6:    t = (ua < ub);
            3'd7:    t = (ua >= ub);
            default: legal = 0;
        endcase
        e.taken   = ib && legal && t;
        e.illegal = ib && !legal;
        e.mispred = (e.taken != pt);
        e.counted = ib && legal;
        nxt       = longint'(pcv) + (e.taken ? longint'(immv) : 64'sd4);
        e.rpc     = nxt[XLEN-1:0];
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_op(logic ib, logic [2:0] bt, logic [XLEN-1:0] av, logic [XLEN-1:0] bv,
                           logic [XLEN-1:0] pcv, logic [XLEN-1:0] immv, logic pt);
        bit done = 0;
        int tries = 0;
        in_valid    = 1'b1;
        is_branch   = ib;
        branch_type = bt;
        a           = av;
        b           = bv;
        pc          = pcv;
        imm         = immv;
        pred_taken  = pt;
        while (!done) begin
            @(negedge clk);
            #1;
            if (in_ready && !flush) begin
                exp_q.push_back(model(ib, bt, av, bv, pcv, immv, pt));
                done = 1;
            end
            @(posedge clk);
            #1;
            tries++;
            if (!done && tries > 200) begin
                check("accept_timeout", 1, 0);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [XLEN-1:0] av, bv;
        int unsigned     sel;
        av  = $urandom;
        bv  = $urandom;
        sel = $urandom_range(0, 3);
        if (sel == 0) bv = av;
        else if (sel == 1) bv = av ^ 32'h8000_0000;
        else if (sel == 2) begin
            av = $urandom_range(0, 3);
            bv = $urandom_range(0, 3);
        end
        send_op(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), av, bv,
                $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    task automatic do_flush(bit offer);
        if (offer) begin
            in_valid    = 1'b1;
            is_branch   = 1'b1;
            branch_type = 3'b000;
            a           = $urandom;
            b           = a;
        end
        flush = 1'b1;
        @(negedge clk);
        #2;
        exp_q.delete();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) check("drain_timeout", 1, 0);
    endtask

    task automatic measure_latency(string name);
        int lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(name, lat, PIPE_DEPTH);
    endtask

    // Monitor: decoupled from stimulus, samples on the falling edge.
    initial begin
        exp_t            e;
        bit              prev_stall = 0;
        bit              prev_flush = 0;
        logic            prev_t, prev_m, prev_i;
        logic [XLEN-1:0] prev_pc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
                continue;
            end
            check("stat_branches", stat_branches, stat_exp(model_br));
            check("stat_mispredicts", stat_mispredicts, stat_exp(model_mp));
            check("in_ready", in_ready, (out_ready || exp_q.size() < PIPE_DEPTH));
            if (prev_stall && !prev_flush) begin
                check("stall_valid", out_valid, 1);
                check("stall_taken", taken, prev_t);
                check("stall_mispredict", mispredict, prev_m);
                check("stall_illegal", illegal, prev_i);
                check("stall_redirect_pc", redirect_pc, prev_pc);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("taken", taken, e.taken);
                    check("mispredict", mispredict, e.mispred);
                    check("illegal", illegal, e.illegal);
                    check("redirect_pc", redirect_pc, e.rpc);
                    if (e.counted) begin
                        if (model_br < SAT) model_br++;
                        if (e.mispred && model_mp < SAT) model_mp++;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_flush = flush;
            prev_t     = taken;
            prev_m     = mispredict;
            prev_i     = illegal;
            prev_pc    = redirect_pc;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        flush       = 1'b0;
        is_branch   = 1'b0;
        branch_type = 3'b000;
        a           = '0;
        b           = '0;
        pc          = '0;
        imm         = '0;
        pred_taken  = 1'b0;
        out_ready   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_taken", taken, 0);
        check("reset_mispredict", mispredict, 0);
        check("reset_illegal", illegal, 0);
        check("reset_redirect_pc", redirect_pc, 0);
        check("reset_stat_branches", stat_branches, 0);
        check("reset_stat_mispredicts", stat_mispredicts, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);

        // Signed versus unsigned on the same operands, with latency.
        send_op(1'b1, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_1000, 32'h0000_0040, 1'b0);
        measure_latency("latency_blt");
        wait_drain();
        send_op(1'b1, 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_1000, 32'h0000_0040, 1'b0);
        measure_latency("latency_bltu");
        wait_drain();

        // BGE on equal negatives, target wraps past 2^XLEN.
        send_op(1'b1, 3'b101, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF0, 32'h0000_0020, 1'b0);
        wait_drain();

        // Reserved funct3 and a non-branch pass-through.
        send_op(1'b1, 3'b010, 32'h1234_5678, 32'h1234_5678, 32'h0000_2000, 32'h0000_0100, 1'b1);
        send_op(1'b0, 3'b000, 32'h5, 32'h5, 32'hFFFF_FFFE, 32'h0000_0100, 1'b1);
        wait_drain();

        // Back-to-back stream with a 5-cycle stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand();
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Flush with two ops in flight and a third offered.
        out_ready = 1'b0;
        send_rand();
        send_rand();
        do_flush(1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("flush_out_valid", out_valid, 0);
            @(posedge clk);
            #1;
        end
        send_op(1'b1, 3'b001, 32'h1, 32'h2, 32'h0000_3000, 32'hFFFF_FFF8, 1'b1);
        wait_drain();

        // Randomized traffic with random backpressure and occasional flushes.
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            r = $urandom_range(0, 29);
            if (r == 0) do_flush(1'($urandom_range(0, 1)));
            else if (r < 8) begin
                @(posedge clk);
                #1;
            end else send_rand();
        end
        rand_ready = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();

        // Mispredicting BNE stream: counters saturate.
        for (int i = 0; i < 20; i++) begin
            logic [XLEN-1:0] av;
            av = $urandom;
            send_op(1'b1, 3'b001, av, av ^ 32'h1, $urandom, $urandom, 1'b0);
        end
        wait_drain();
        @(posedge clk);
        #1;
        check("sat_stat_branches", stat_branches, stat_exp(model_br));
        check("sat_stat_mispredicts", stat_mispredicts, stat_exp(model_mp));

        // Asynchronous reset with a full pipeline.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_stat_branches", stat_branches, 0);
        check("async_rst_stat_mispredicts", stat_mispredicts, 0);
        check("async_rst_redirect_pc", redirect_pc, 0);
        exp_q.delete();
        model_br = 0;
        model_mp = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_out_valid", out_valid, 0);
        send_op(1'b1, 3'b111, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_4000, 32'h0000_0010, 1'b1);
        measure_latency("latency_post_reset");
        wait_drain();

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
